exe_arbiter: RTL and testbench

Two-requester arbiter and result buffer that shares the single 32-bit execute-stage ALU between two independent issue ports. It sits directly in front of the ALU instance. It selects one request per cycle with round-robin fairness and drives the ALU operands and `ALU_operation` from the winner. It then captures `ALU_result`/`Zero_signal` into a one-entry output register with a valid/ready handshake toward the consumer.

---
 rtl/exe_arbiter.sv | 90 +++++++++
 tb/tb_exe_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/exe_arbiter.sv
// exe_arbiter: round-robin arbiter sharing one 32-bit ALU between two issue ports,
// followed by a one-entry valid/ready result register toward the consumer.
module exe_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [3:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] ALU_result,
  output logic             Zero_signal
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic             last_grant;
  logic             any_req;
  logic             grant;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_diff;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_op;

  assign resp_valid = (state == FULL);

  // Round-robin grant: on contention the requester not granted last wins.
  always_comb begin
    any_req    = req0_valid | req1_valid;
    grant      = req1_valid & (~req0_valid | ~last_grant);
    can_accept = (state == EMPTY) | resp_ready;
    accept     = can_accept & any_req & ~reset;
    req0_ready = accept & ~grant;
    req1_ready = accept & grant;
  end

  // Shared ALU; with no grant the operands default to requester 0 and are ignored.
  always_comb begin
    alu_a    = grant ? req1_A  : req0_A;
    alu_b    = grant ? req1_B  : req0_B;
    alu_op   = grant ? req1_op : req0_op;
    alu_diff = alu_a - alu_b;
    alu_out  = '0;
    casez (alu_op)
      4'b?000: alu_out = alu_a & alu_b;
      4'b?001: alu_out = alu_a | alu_b;
      4'b?010: alu_out = alu_a + alu_b;
      4'b?110: alu_out = alu_diff;
      4'b?111: alu_out = {{(WIDTH-1){1'b0}}, alu_diff[WIDTH-1]};
      default: alu_out = '0;
    endcase
  end

  // Result register; a drain and a new accept on the same edge keep it full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      resp_id     <= 1'b0;
      ALU_result  <= '0;
      Zero_signal <= 1'b0;
      last_grant  <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (accept) state <= FULL;
        FULL:  if (!accept && resp_ready) state <= EMPTY;
      endcase
      if (accept) begin
        ALU_result  <= alu_out;
        Zero_signal <= (alu_out == '0);
        resp_id     <= grant;
        last_grant  <= grant;
      end
    end
  end

endmodule

// File: tb/tb_exe_arbiter.sv
// Randomized and directed bench for exe_arbiter against a behavioural model.
module tb_exe_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_A, req0_B, req1_A, req1_B;
  logic [3:0]  req0_op, req1_op;
  logic        resp_valid, resp_ready, resp_id, Zero_signal;
  logic [31:0] ALU_result;

  exe_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_A(req1_A), .req1_B(req1_B), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .ALU_result(ALU_result), .Zero_signal(Zero_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state
  bit          m_valid, m_id, m_last, m_zero;
  logic [31:0] m_result;
  bit          acc_q, g_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    case (op % 8)
      0:       return a & b;
      1:       return a | b;
      2:       return a + b;
      6:       return d;
      7:       return d >> 31;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_last = 1; m_zero = 0; m_result = 32'd0;
  endtask

  // Entered at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle();
    bit can, g, acc;
    #3;
    can = !m_valid || resp_ready;
    if (req0_valid && req1_valid) g = !m_last;
    else g = req1_valid;
    acc = can && (req0_valid || req1_valid);
    check("req0_ready", 32'(req0_ready), 32'(acc && !g));
    check("req1_ready", 32'(req1_ready), 32'(acc && g));
    @(posedge clk);
    if (acc) begin
      m_result = g ? alu_ref(req1_op, req1_A, req1_B) : alu_ref(req0_op, req0_A, req0_B);
      m_zero   = (m_result == 0);
      m_id     = g;
      m_last   = g;
      m_valid  = 1;
    end else if (m_valid && resp_ready) begin
      m_valid = 0;
    end
    acc_q = acc;
    g_q   = g;
    #1;
    check("resp_valid", 32'(resp_valid), 32'(m_valid));
    check("resp_id", 32'(resp_id), 32'(m_id));
    check("ALU_result", ALU_result, m_result);
    check("Zero_signal", 32'(Zero_signal), 32'(m_zero));
  endtask

  logic [3:0]  t_op  [5] = '{4'b0110, 4'b0111, 4'b0000, 4'b0101, 4'b1010};
  logic [31:0] t_a   [5] = '{32'd9, 32'hFFFF_FFFF, 32'h0000_F0F0, 32'd3, 32'd5};
  logic [31:0] t_b   [5] = '{32'd9, 32'd1, 32'h0000_0FF0, 32'd4, 32'd7};
  logic [31:0] t_exp [5] = '{32'd0, 32'd1, 32'h0000_00F0, 32'd0, 32'd12};

  initial begin
    logic [31:0] held;
    reset = 0; resp_ready = 0;
    req0_valid = 0; req0_A = 0; req0_B = 0; req0_op = 0;
    req1_valid = 0; req1_A = 0; req1_B = 0; req1_op = 0;
    acc_q = 0; g_q = 0;
    model_reset();

    // Reset with a pending request
    #1 reset = 1;
    req0_valid = 1; req0_op = 4'b0010; req0_A = 32'd5; req0_B = 32'd7;
    @(posedge clk); #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_result", ALU_result, 32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    reset = 0;
    resp_ready = 1;
    cycle();
    check("add_result", ALU_result, 32'd12);
    check("add_zero", 32'(Zero_signal), 32'd0);
    check("add_id", 32'(resp_id), 32'd0);

    // Op coverage through requester 1
    req0_valid = 0;
    req1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      req1_op = t_op[i]; req1_A = t_a[i]; req1_B = t_b[i];
      cycle();
      check("op_result", ALU_result, t_exp[i]);
      check("op_zero", 32'(Zero_signal), 32'(t_exp[i] == 0));
      check("op_id", 32'(resp_id), 32'd1);
    end

    // Contention: alternating grants at full throughput
    req0_valid = 1; req1_valid = 1;
    req0_op = 4'b0010; req1_op = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      req0_A = 32'(i); req0_B = 32'd100; req1_A = 32'(i << 4); req1_B = 32'd1;
      cycle();
      check("cont_id", 32'(resp_id), 32'(i % 2));
      check("cont_valid", 32'(resp_valid), 32'd1);
    end

    // Backpressure: held result stays put, then drain+accept on one edge
    resp_ready = 0;
    held = ALU_result;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_held", ALU_result, held);
      check("bp_id", 32'(resp_id), 32'd1);
    end
    resp_ready = 1;
    cycle();
    check("bp_release_valid", 32'(resp_valid), 32'd1);
    check("bp_release_id", 32'(resp_id), 32'd0);

    // Fairness memory survives idle cycles
    req0_valid = 0; req1_valid = 1;
    cycle();
    check("fair_r1", 32'(resp_id), 32'd1);
    req1_valid = 0;
    for (int i = 0; i < 4; i++) cycle();
    req0_valid = 1; req1_valid = 1;
    cycle();
    check("fair_r0", 32'(resp_id), 32'd0);

    // Mid-flight asynchronous reset
    req0_valid = 0; req1_valid = 1;
    cycle();
    check("mid_id", 32'(resp_id), 32'd1);
    req1_valid = 0; resp_ready = 0;
    #2 reset = 1;
    req0_valid = 1;
    #1;
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_ready", 32'(req0_ready), 32'd0);
    check("mid_rst_result", ALU_result, 32'd0);
    #1 reset = 0;
    req0_valid = 0;
    model_reset();
    @(posedge clk); #1;
    req0_valid = 1; req1_valid = 1; resp_ready = 1;
    cycle();
    check("mid_after_id", 32'(resp_id), 32'd0);

    // Randomized traffic honouring the valid/ready operand-stability contract
    for (int i = 0; i < 400; i++) begin
      if (!(req0_valid && !(acc_q && !g_q))) begin
        req0_valid = ($urandom_range(0, 9) < 6);
        req0_A     = $urandom;
        req0_B     = ($urandom_range(0, 3) == 0) ? req0_A : $urandom;
        req0_op    = 4'($urandom);
      end
      if (!(req1_valid && !(acc_q && g_q))) begin
        req1_valid = ($urandom_range(0, 9) < 6);
        req1_A     = $urandom;
        req1_B     = ($urandom_range(0, 3) == 0) ? req1_A : $urandom;
        req1_op    = 4'($urandom);
      end
      resp_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
